// File: rtl/slow_to_fast_pkg.sv
// slow_to_fast_pkg: shared FSM state type, default sizes and counter-width helper for slow_to_fast.
package slow_to_fast_pkg;
    localparam int S_DEFAULT      = 12;
    localparam int SETTLE_DEFAULT = 2;

    typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE} s2f_state_t;

    function automatic int cnt_width(input int settle);
        return (settle < 2) ? 1 : $clog2(settle + 1);
    endfunction
endpackage

// File: rtl/slow_to_fast_if.sv
// slow_to_fast_if: slow-domain input bus and fast-domain result bus of slow_to_fast.
interface slow_to_fast_if import slow_to_fast_pkg::*; #(parameter int S = S_DEFAULT);
    logic         slow_clk;
    logic [S-1:0] slow_data;
    logic         data_ack;
    logic [S-1:0] sync_data;
    logic         data_valid;
    logic         overrun;

    modport master (output slow_clk, slow_data, data_ack, input sync_data, data_valid, overrun);
    modport slave  (input slow_clk, slow_data, data_ack, output sync_data, data_valid, overrun);
endinterface

// File: rtl/slow_to_fast_edge_det.sv
// slow_clk_edge_det: three-flop synchronizer on slow_clk with a one-cycle rising-edge strobe.
module slow_clk_edge_det (
    input  logic fast_clk,
    input  logic clr,
    input  logic slow_clk_i,
    output logic rise_o
);
    logic [2:0] sync_q;

    always_ff @(posedge fast_clk or posedge clr)
        if (clr) sync_q <= '0;
        else     sync_q <= {sync_q[1:0], slow_clk_i};

    assign rise_o = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/slow_to_fast.sv
// slow_to_fast: captures a slow-domain word into the fast domain a fixed settle time after each slow_clk rise.
// SLOW_TO_FAST_HANDSHAKE_EN selects level valid/ack with sticky overrun; otherwise data_valid is a pulse.
module slow_to_fast #(
    parameter int S      = slow_to_fast_pkg::S_DEFAULT,
    parameter int SETTLE = slow_to_fast_pkg::SETTLE_DEFAULT
) (
    input logic           fast_clk,
    input logic           clr,
    slow_to_fast_if.slave bus
);
    import slow_to_fast_pkg::*;

    localparam int            CW   = cnt_width(SETTLE);
    localparam logic [CW-1:0] LAST = CW'(SETTLE == 0 ? 0 : SETTLE - 1);

    s2f_state_t    state_q;
    logic [CW-1:0] cnt_q;
    logic [S-1:0]  data_q;
    logic          valid_q, valid_d;
    logic          ovr_q, ovr_d;
    logic          rise, capture;

    slow_clk_edge_det u_edge (
        .fast_clk   (fast_clk),
        .clr        (clr),
        .slow_clk_i (bus.slow_clk),
        .rise_o     (rise)
    );

    assign capture = state_q == CAPTURE;

    // Edges arriving outside IDLE are simply ignored by the FSM.
    always_ff @(posedge fast_clk or posedge clr)
        if (clr) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (rise) begin
                    state_q <= (SETTLE == 0) ? CAPTURE : slow_to_fast_pkg::SETTLE;
                    cnt_q   <= '0;
                end
                slow_to_fast_pkg::SETTLE: if (cnt_q == LAST) state_q <= CAPTURE;
                                          else cnt_q <= cnt_q + 1'b1;
                default: begin
                    data_q  <= bus.slow_data;
                    state_q <= IDLE;
                end
            endcase
        end

`ifdef SLOW_TO_FAST_HANDSHAKE_EN
    always_comb begin
        valid_d = capture | (valid_q & ~bus.data_ack);
        ovr_d   = ovr_q | (capture & valid_q & ~bus.data_ack) | (rise & (state_q != IDLE));
    end
`else
    logic unused_ack;
    assign unused_ack = bus.data_ack;
    always_comb begin
        valid_d = capture;
        ovr_d   = 1'b0;
    end
`endif

    always_ff @(posedge fast_clk or posedge clr)
        if (clr) begin
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end

    assign bus.sync_data  = data_q;
    assign bus.data_valid = valid_q;
    assign bus.overrun    = ovr_q;
endmodule
